// File: rtl/cpu_pkg.sv
// Shared sequencer types: state encoding, opcodes, address width,
// and the wrapping PC increment helper.
package cpu_pkg;

    localparam int ADDR_W = 8;

    localparam logic [7:0] OPC_NOP = 8'h00;
    localparam logic [7:0] OPC_HLT = 8'hF0;

    typedef enum logic [2:0] {
        SEQ_IDLE      = 3'd0,
        SEQ_FETCH     = 3'd1,
        SEQ_DECODE    = 3'd2,
        SEQ_EXECUTE   = 3'd3,
        SEQ_HALT      = 3'd4,
        SEQ_STEP_WAIT = 3'd5
    } seq_state_t;

    // Natural modulo-2^ADDR_W increment: 8'hFF rolls to 8'h00.
    function automatic logic [ADDR_W-1:0] pc_inc(
        input logic [ADDR_W-1:0] v
    );
        return v + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction-memory fetch bus between the sequencer and memory.
// master: imem_req/imem_addr out, imem_ack/imem_data in. slave: mirror.
interface instr_sequencer_if;
    import cpu_pkg::*;

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [7:0]        imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );

endinterface

// File: rtl/program_counter.sv
// Program counter register with increment/jump source mux.
// Ports: clk, reset (async high), load, sel (0 inc, 1 jump), target, pc.
module program_counter
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              sel,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = sel ? target : pc_inc(pc_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer with fetch timeout fault and halt.
// Ports: clk, reset (async high), run, imem (fetch bus master),
//   opcode, cu_write_pc, cu_pc_sel, jmp_target, exec_en, pc,
//   busy, halted, fault; step only when SINGLE_STEP_EN is defined.
// Macro SINGLE_STEP_EN: pause in STEP_WAIT after every instruction.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int                TIMEOUT_CYCLES = 15,
    parameter logic [ADDR_W-1:0] RESET_PC       = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    instr_sequencer_if.master imem,
    output logic [7:0]        opcode,
    input  logic              cu_write_pc,
    input  logic              cu_pc_sel,
    input  logic [ADDR_W-1:0] jmp_target,
    output logic              exec_en,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              fault
`ifdef SINGLE_STEP_EN
    ,
    input  logic              step
`endif
);

    localparam logic [2:0] ST_IDLE    = SEQ_IDLE;
    localparam logic [2:0] ST_FETCH   = SEQ_FETCH;
    localparam logic [2:0] ST_DECODE  = SEQ_DECODE;
    localparam logic [2:0] ST_EXECUTE = SEQ_EXECUTE;
    localparam logic [2:0] ST_HALT    = SEQ_HALT;
`ifdef SINGLE_STEP_EN
    localparam logic [2:0] ST_STEP    = SEQ_STEP_WAIT;
`endif

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Last un-acked FETCH cycle before the fault fires.
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        op_q, op_d;
    logic              fault_q, fault_d;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_w;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        fault_d = fault_q;
        pc_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                    cnt_d   = '0;
                end
            end
            ST_FETCH: begin
                if (imem.imem_ack) begin
                    op_d    = imem.imem_data;
                    state_d = ST_DECODE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HALT;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DECODE: begin
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                pc_load = cu_write_pc;
                if (op_q == OPC_HLT) begin
                    state_d = ST_HALT;
                end else if (!run) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = '0;
`ifdef SINGLE_STEP_EN
                    state_d = ST_STEP;
`else
                    state_d = ST_FETCH;
`endif
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
`ifdef SINGLE_STEP_EN
            ST_STEP: begin
                if (step) begin
                    state_d = ST_FETCH;
                    cnt_d   = '0;
                end else if (!run) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OPC_NOP;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            fault_q <= fault_d;
        end
    end

    program_counter #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk    (clk),
        .reset  (reset),
        .load   (pc_load),
        .sel    (cu_pc_sel),
        .target (jmp_target),
        .pc     (pc_w)
    );

    // Status is decoded from state so reset clears it asynchronously.
    assign imem.imem_req  = (state_q == ST_FETCH);
    assign imem.imem_addr = pc_w;
    assign opcode         = op_q;
    assign exec_en        = (state_q == ST_EXECUTE);
    assign pc             = pc_w;
    assign busy           = (state_q == ST_FETCH)
                          | (state_q == ST_DECODE)
                          | (state_q == ST_EXECUTE);
    assign halted         = (state_q == ST_HALT);
    assign fault          = fault_q;

endmodule
